// File: rtl/lcd_bus_writer_pkg.sv
// lcd_bus_writer_pkg: FSM states, LCD command bytes and long-command test for the LCD bus writer
package lcd_bus_writer_pkg;
  typedef enum logic [2:0] {
    LCDW_PWRUP,
    LCDW_IDLE,
    LCDW_SETUP,
    LCDW_PULSE,
    LCDW_HOLD,
    LCDW_WAIT
  } lcdw_state_t;
  localparam logic [7:0] LCD_CLEAR      = 8'h01;
  localparam logic [7:0] LCD_HOME       = 8'h02;
  localparam logic [7:0] LCD_ENTRY_MODE = 8'h06;
  localparam logic [7:0] LCD_DISPLAY_ON = 8'h0C;
  localparam logic [7:0] LCD_FUNC_SET   = 8'h38;
  localparam logic [7:0] LCD_DB_IDLE    = 8'hCC;
  function automatic logic lcd_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && data[7:2] == 6'd0;
  endfunction
endpackage

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: HD44780 bus-timing transmitter with setup, enable pulse, hold and execution wait
module lcd_bus_writer
  import lcd_bus_writer_pkg::*;
#(
  parameter int         PWRUP_CYC = 750000,
  parameter int         SETUP_CYC = 2,
  parameter int         PULSE_CYC = 12,
  parameter int         HOLD_CYC  = 1,
  parameter int         EXEC_CYC  = 2000,
  parameter int         LONG_CYC  = 82000,
  parameter logic [7:0] DB_IDLE   = LCD_DB_IDLE,
  parameter int         CNT_W     = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db
);
  lcdw_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic rs_q;
  logic [7:0] db_q;
  logic done, pwrup_done, active;
  assign done       = cnt == '0;
  assign pwrup_done = cnt == CNT_W'(PWRUP_CYC - 1);
  assign active     = state != LCDW_IDLE && state != LCDW_PWRUP;
  assign wr_ready   = state == LCDW_IDLE;
  assign busy       = ~wr_ready;
  assign lcd_rw     = 1'b0;
  assign lcd_rs     = active ? rs_q : 1'b0;
  assign lcd_db     = active ? db_q : DB_IDLE;
  always_comb begin
    state_n = state;
    cnt_n   = done ? '0 : cnt - 1'b1;
    unique case (state)
      LCDW_PWRUP: begin
        state_n = pwrup_done ? LCDW_IDLE : LCDW_PWRUP;
        cnt_n   = pwrup_done ? '0 : cnt + 1'b1;
      end
      LCDW_IDLE: if (wr_req) begin
        state_n = LCDW_SETUP;
        cnt_n   = CNT_W'(SETUP_CYC - 1);
      end
      LCDW_SETUP: if (done) begin
        state_n = LCDW_PULSE;
        cnt_n   = CNT_W'(PULSE_CYC - 1);
      end
      LCDW_PULSE: if (done) begin
        state_n = LCDW_HOLD;
        cnt_n   = CNT_W'(HOLD_CYC - 1);
      end
      LCDW_HOLD: if (done) begin
        state_n = LCDW_WAIT;
        cnt_n   = lcd_long_cmd(rs_q, db_q) ? CNT_W'(LONG_CYC - 1) : CNT_W'(EXEC_CYC - 1);
      end
      default: if (done) state_n = LCDW_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LCDW_PWRUP;
      cnt   <= '0;
      rs_q  <= 1'b0;
      db_q  <= DB_IDLE;
      lcd_e <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      lcd_e <= state_n == LCDW_PULSE;
      if (wr_ready && wr_req) begin
        rs_q <= wr_rs;
        db_q <= wr_data;
      end
    end
  end
endmodule

// File: tb/tb_lcd_bus_writer.sv
// tb_lcd_bus_writer: randomized and directed check of lcd_bus_writer against a phase-timeline model
module tb_lcd_bus_writer;
  localparam int PW = 5;
  localparam int S  = 2;
  localparam int P  = 3;
  localparam int H  = 1;
  localparam int E  = 4;
  localparam int L  = 9;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_req = 1'b0;
  logic wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic wr_ready, busy, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_db;
  int checks = 0;
  int errors = 0;
  int pw_left = 0;
  int t = -1;
  int len = 0;
  logic m_rs = 1'b0;
  logic [7:0] m_db = 8'h00;
  always #5 clk = ~clk;
  lcd_bus_writer #(
    .PWRUP_CYC(PW), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H),
    .EXEC_CYC(E), .LONG_CYC(L), .DB_IDLE(8'hCC), .CNT_W(20)
  ) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_rs(wr_rs), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_db(lcd_db)
  );
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed %h expected %h", tag, $time, got, exp);
    end
  endtask
  task automatic cycle(input logic rst, input logic req, input logic rs, input logic [7:0] d);
    logic ready_x, e_x, rs_x;
    logic [7:0] db_x;
    reset = rst;
    wr_req = req;
    wr_rs = rs;
    wr_data = d;
    @(posedge clk);
    if (rst) begin
      pw_left = PW;
      t = -1;
    end else if (pw_left > 0) begin
      pw_left--;
    end else if (t < 0) begin
      if (req) begin
        t = 0;
        m_rs = rs;
        m_db = d;
        len = S + P + H + ((!rs && d < 8'd4) ? L : E);
      end
    end else begin
      t++;
      if (t == len) t = -1;
    end
    @(negedge clk);
    ready_x = pw_left == 0 && t < 0;
    e_x = t >= S && t < S + P;
    rs_x = t >= 0 ? m_rs : 1'b0;
    db_x = t >= 0 ? m_db : 8'hCC;
    chk("wr_ready", {7'd0, wr_ready}, {7'd0, ready_x});
    chk("busy", {7'd0, busy}, {7'd0, !ready_x});
    chk("lcd_e", {7'd0, lcd_e}, {7'd0, e_x});
    chk("lcd_rs", {7'd0, lcd_rs}, {7'd0, rs_x});
    chk("lcd_rw", {7'd0, lcd_rw}, 8'd0);
    chk("lcd_db", lcd_db, db_x);
  endtask
  initial begin
    cycle(1, 0, 0, 8'h00);
    cycle(1, 0, 0, 8'h00);
    repeat (7) cycle(0, 0, 0, 8'h00);
    cycle(0, 1, 1, 8'h41);
    repeat (11) cycle(0, 0, 0, 8'h00);
    cycle(0, 1, 0, 8'h01);
    repeat (11) cycle(0, 0, 1, 8'hFF);
    cycle(0, 1, 0, 8'h38);
    repeat (11) cycle(0, 0, 0, 8'h00);
    repeat (40) cycle(0, 1, 1'($urandom), 8'($urandom));
    repeat (300)
      cycle(0, ($urandom % 3) != 0, 1'($urandom), ($urandom % 2) != 0 ? 8'($urandom % 4) : 8'($urandom));
    repeat (20) cycle(0, 0, 0, 8'h00);
    cycle(0, 1, 1, 8'h5A);
    cycle(0, 0, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);
    chk("pulse_before_reset", {7'd0, lcd_e}, 8'd1);
    cycle(1, 0, 0, 8'h00);
    chk("pulse_abort", {7'd0, lcd_e}, 8'd0);
    repeat (8) cycle(0, 1, 1, 8'hA5);
    repeat (15) cycle(0, 0, 0, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
